// File: rtl/regfile_sequencer_if.sv
// Command and register-file bus of the register-file sequencer.
// master: command issuer plus register-file side; slave: the sequencer.
interface regfile_sequencer_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs;
  logic [DW-1:0] imm;
  logic [DW-1:0] rf_data_out;
  logic [DW-1:0] rf_data_in;
  logic [AW-1:0] rf_writenum;
  logic [AW-1:0] rf_readnum;
  logic          rf_write;
  logic          busy;
  logic          done;

  modport master (
    output start, op, rd, rs, imm, rf_data_out,
    input  rf_data_in, rf_writenum, rf_readnum, rf_write, busy, done
  );

  modport slave (
    input  start, op, rd, rs, imm, rf_data_out,
    output rf_data_in, rf_writenum, rf_readnum, rf_write, busy, done
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Register-file sequencer: executes one LOADIMM / MOVE / SWAP / CLEARALL
// command per start/done handshake against an 8x16 register file.
// All outputs are Moore outputs decoded from state and latched operands.
module regfile_sequencer #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input logic                clk,
  input logic                reset,
  regfile_sequencer_if.slave bus
);
  localparam int NREG = 2 ** AW;

  localparam logic [1:0] OP_LOADIMM  = 2'b00;
  localparam logic [1:0] OP_MOVE     = 2'b01;
  localparam logic [1:0] OP_SWAP     = 2'b10;

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_WR_IMM = 3'd1;
  localparam logic [2:0] S_RD_A   = 3'd2;
  localparam logic [2:0] S_RD_B   = 3'd3;
  localparam logic [2:0] S_WR_A   = 3'd4;
  localparam logic [2:0] S_WR_B   = 3'd5;
  localparam logic [2:0] S_CLR    = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]    state_reg;
  logic [2:0]    state_next;
  logic [1:0]    op_reg;
  logic [AW-1:0] rd_reg;
  logic [AW-1:0] rs_reg;
  logic [DW-1:0] imm_reg;
  logic [DW-1:0] tmp_a_reg;
  logic [DW-1:0] tmp_b_reg;
  // One extra bit so reaching NREG (terminal count) shows up as the MSB.
  logic [AW:0]   count_reg;
  logic [AW:0]   count_inc;

  assign count_inc = count_reg + (AW + 1)'(1);

  // Next-state selection; the command op is only examined while waiting.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT: begin
        if (bus.start) begin
          case (bus.op)
            OP_LOADIMM: state_next = S_WR_IMM;
            OP_MOVE,
            OP_SWAP:    state_next = S_RD_A;
            default:    state_next = S_CLR;
          endcase
        end
      end
      S_WR_IMM: state_next = S_DONE;
      S_RD_A:   state_next = (op_reg == OP_SWAP) ? S_RD_B : S_WR_A;
      S_RD_B:   state_next = S_WR_A;
      S_WR_A:   state_next = (op_reg == OP_SWAP) ? S_WR_B : S_DONE;
      S_WR_B:   state_next = S_DONE;
      S_CLR:    state_next = count_inc[AW] ? S_DONE : S_CLR;
      S_DONE:   state_next = S_WAIT;
      default:  state_next = S_WAIT;
    endcase
  end

  // State, operand latches, read captures and clear counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_WAIT;
      op_reg    <= '0;
      rd_reg    <= '0;
      rs_reg    <= '0;
      imm_reg   <= '0;
      tmp_a_reg <= '0;
      tmp_b_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_WAIT && bus.start) begin
        op_reg  <= bus.op;
        rd_reg  <= bus.rd;
        rs_reg  <= bus.rs;
        imm_reg <= bus.imm;
      end
      if (state_reg == S_RD_A) tmp_a_reg <= bus.rf_data_out;
      if (state_reg == S_RD_B) tmp_b_reg <= bus.rf_data_out;
      if (state_reg == S_CLR) count_reg <= count_inc[AW] ? '0 : count_inc;
    end
  end

  // Output decode: write-port fields stay zero whenever no write is issued.
  always_comb begin
    bus.rf_write    = 1'b0;
    bus.rf_writenum = '0;
    bus.rf_data_in  = '0;
    bus.rf_readnum  = '0;
    bus.busy        = (state_reg != S_WAIT);
    bus.done        = (state_reg == S_DONE);
    case (state_reg)
      S_WR_IMM: begin
        bus.rf_write    = 1'b1;
        bus.rf_writenum = rd_reg;
        bus.rf_data_in  = imm_reg;
      end
      S_RD_A: bus.rf_readnum = rs_reg;
      S_RD_B: bus.rf_readnum = rd_reg;
      S_WR_A: begin
        bus.rf_write    = 1'b1;
        bus.rf_writenum = rd_reg;
        bus.rf_data_in  = tmp_a_reg;
      end
      S_WR_B: begin
        bus.rf_write    = 1'b1;
        bus.rf_writenum = rs_reg;
        bus.rf_data_in  = tmp_b_reg;
      end
      S_CLR: begin
        bus.rf_write    = 1'b1;
        bus.rf_writenum = count_reg[AW-1:0];
      end
      default: ;
    endcase
  end
endmodule
